ion_sensor_request_arbiter: RTL and testbench
=============================================

# ion_sensor_request_arbiter

Sits directly downstream of the per-stream periodic request generators. It collects their single-cycle request pulses into per-stream pending flags, selects one stream at a time round-robin, and issues it as a command to the ion sensor interface over a valid/ready handshake. It then holds off further commands until the sensor reports completion. Overlapping requests and stalled transactions are flagged to the control logic.

## Interface
- `timeout_cycles`, default 16'd50000: cycles to wait for `cmd_done` after a command is accepted; used only with `ISR_TIMEOUT_EN`. Must be ≥1.
- `clock` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `stream_active` input 8: per-stream enable. A low bit clears that stream's pending and overrun state.
- `i_s_request` input 8: single-cycle request pulses, one bit per stream.
- `cmd_ready` input 1: sensor interface accepts the command this cycle.
- `cmd_done` input 1: single-cycle pulse; sensor transaction finished.
- `cmd_valid` output 1: command offered.
- `cmd_stream` output 3: index of the granted stream. Stable while `cmd_valid` is high.
- `pending` output 8: registered per-stream pending flags.
- `overrun` output 8: sticky flag per stream; set when a request arrives while that stream is already pending.
- `busy` output 1: high when the state is not IDLE.
- `timeout` output 1: single-cycle pulse when the wait for `cmd_done` is abandoned.

## Operation
- Pending set: `pending[k]` sets when `i_s_request[k] & stream_active[k]`.
  - Requests on inactive streams are ignored.
- Overrun: a request with `pending[k]` already 1 sets `overrun[k]`.
  - `overrun[k]` clears only on reset or when `stream_active[k]` is low.
- Pending clear: `pending[k]` clears when stream k is granted (IDLE→ISSUE) or when `stream_active[k]` is low.
  - A grant-clear and a new request in the same cycle: the set wins, and no overrun is flagged.
- Round-robin pointer `last_grant`, 3 bits:
  - Search order is `last_grant+1`, `last_grant+2`, … modulo 8.
  - The first pending bit found is granted.
  - `last_grant` updates on grant.
- FSM states:
  - IDLE:
    - If any `pending` bit is set, go to ISSUE.
    - Register the `cmd_stream` and set `cmd_valid`=1.
  - ISSUE:
    - `cmd_valid`=1 and `cmd_stream` are held until `cmd_ready`.
    - On `cmd_valid & cmd_ready`, go to WAIT with `cmd_valid`=0.
    - Deasserting `stream_active` for the granted stream does not withdraw the command.
  - WAIT:
    - On `cmd_done`, go to IDLE.
    - With `ISR_TIMEOUT_EN`, the timeout path also returns to IDLE (see Configuration).
- `cmd_done` in IDLE or ISSUE is ignored.
- New requests are captured in every state.

## Timing
- Reset values:
  - `cmd_valid`=0, `cmd_stream`=0, `pending`=0, `overrun`=0, `busy`=0, `timeout`=0.
  - State is IDLE, `last_grant`=7 (stream 0 has first priority), timeout counter is 0.
- Request-to-command latency:
  - A pulse at cycle N gives `pending[k]`=1 at N+1.
  - If the block is idle, `cmd_valid`=1 at N+2.
- Handshake: transfer happens in the cycle where `cmd_valid` and `cmd_ready` are both high. `cmd_ready` may already be high when `cmd_valid` rises.
- Accept at cycle M: `cmd_valid`=0 and the state is WAIT at M+1.
- `cmd_done` at cycle D: the state is IDLE at D+1, and the earliest next `cmd_valid` is D+2.
  - So there is a minimum of one IDLE cycle between commands.
- `reset` asserted mid-transaction aborts it. All state returns to reset values on the next edge, and there is no `timeout` pulse.

## Configuration
- `ISR_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle without `cmd_done`.
  - When the counter reaches `timeout_cycles`, `timeout` pulses for one cycle and the state returns to IDLE.
  - `cmd_done` on the same cycle as expiry takes precedence: no `timeout` pulse.
- `ISR_TIMEOUT_EN` undefined:
  - No counter exists, `timeout` is tied to 0, and WAIT holds until `cmd_done`.

## Test plan
- Single request: reset, `stream_active`=8'hFF, pulse `i_s_request`=8'h04 at cycle 10.
  - Expect `pending`=8'h04 at 11 and `cmd_valid`=1 with `cmd_stream`=2 at 12.
  - With `cmd_ready` high at 12, expect WAIT and `pending`=0 at 13.
- Round-robin: pulse 8'h81 at once; answer each command with `cmd_ready` then `cmd_done`.
  - Expect the grant order 0, 7.
  - Then pulse 8'h81 again: expect 0, 7 (pointer at 7 wraps to 0).
- Overrun: pulse bit 3 twice while stream 3 is still pending, before its grant.
  - Expect `overrun`=8'h08, sticky.
  - Drop `stream_active[3]`: expect `overrun` and `pending[3]` to clear the next cycle.
- Grant/request collision: pulse bit 1 in the same cycle stream 1 is granted from IDLE.
  - Expect `pending[1]` to stay 1 and `overrun[1]`=0.
- Timeout (`ISR_TIMEOUT_EN`, `timeout_cycles`=16'd5): accept a command and never assert `cmd_done`.
  - Expect a one-cycle `timeout` pulse after the 5th WAIT cycle, then IDLE.
  - Without the macro, expect the block to stay in WAIT indefinitely.
- Reset in ISSUE: assert `reset` while `cmd_valid`=1.
  - Expect all outputs at 0 on the next edge.
  - After release, a stream-0 request is granted first.

Source files
------------

// File: rtl/ion_sensor_request_arbiter.sv
// ion_sensor_request_arbiter
// Collects per-stream request pulses into pending flags, grants one stream at
// a time round-robin and issues it as a valid/ready command to the ion sensor
// interface, then waits for cmd_done before issuing the next command.
// Optional feature macro: ISR_TIMEOUT_EN (adds a WAIT-state timeout counter).
module ion_sensor_request_arbiter #(
  parameter logic [15:0] timeout_cycles = 16'd50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] stream_active,
  input  logic [7:0] i_s_request,
  input  logic       cmd_ready,
  input  logic       cmd_done,
  output logic       cmd_valid,
  output logic [2:0] cmd_stream,
  output logic [7:0] pending,
  output logic [7:0] overrun,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] last_grant_reg, last_grant_next;
  logic       cmd_valid_reg, cmd_valid_next;
  logic [2:0] cmd_stream_reg, cmd_stream_next;
  logic [7:0] pending_reg, pending_next;
  logic [7:0] overrun_reg, overrun_next;
  logic       grant_take;
  logic       grant_found;
  logic [2:0] grant_idx;
  logic [7:0] grant_clear;

  // Round-robin search: first pending stream after last_grant, wrapping mod 8
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_reg;
    for (int i = 1; i <= 8; i++) begin
      if (!grant_found && pending_reg[last_grant_reg + 3'(i)]) begin
        grant_found = 1'b1;
        grant_idx   = last_grant_reg + 3'(i);
      end
    end
  end

  assign grant_clear = grant_take ? (8'b1 << grant_idx) : 8'b0;

  // Per-stream pending/overrun next state; a same-cycle request beats the
  // grant-clear and is not treated as an overrun of the stream being granted.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_stream
      assign pending_next[gi] = !stream_active[gi] ? 1'b0 :
                                i_s_request[gi]    ? 1'b1 :
                                grant_clear[gi]    ? 1'b0 : pending_reg[gi];
      assign overrun_next[gi] = !stream_active[gi] ? 1'b0 :
                                (overrun_reg[gi] |
                                 (i_s_request[gi] & pending_reg[gi] & ~grant_clear[gi]));
    end
  endgenerate

`ifdef ISR_TIMEOUT_EN
  logic [15:0] tmr_reg;
  logic        timeout_reg, timeout_next;
  logic        tmr_expire;

  assign tmr_expire = (tmr_reg + 16'd1) == timeout_cycles;

  // WAIT-state cycle counter, restarted whenever a command is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      tmr_reg <= 16'd0;
    end else if (state_reg == ISSUE && cmd_ready) begin
      tmr_reg <= 16'd0;
    end else if (state_reg == WAIT && !cmd_done) begin
      tmr_reg <= tmr_reg + 16'd1;
    end
  end

  // Registered single-cycle timeout pulse
  always_ff @(posedge clock) begin
    if (reset) timeout_reg <= 1'b0;
    else       timeout_reg <= timeout_next;
  end

  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  // FSM next-state and command outputs
  always_comb begin
    state_next      = state_reg;
    cmd_valid_next  = cmd_valid_reg;
    cmd_stream_next = cmd_stream_reg;
    last_grant_next = last_grant_reg;
    grant_take      = 1'b0;
`ifdef ISR_TIMEOUT_EN
    timeout_next    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          state_next      = ISSUE;
          cmd_valid_next  = 1'b1;
          cmd_stream_next = grant_idx;
          last_grant_next = grant_idx;
          grant_take      = 1'b1;
        end
      end
      ISSUE: begin
        // The command is never withdrawn once offered
        if (cmd_ready) begin
          state_next     = WAIT;
          cmd_valid_next = 1'b0;
        end
      end
      WAIT: begin
        if (cmd_done) begin
          state_next = IDLE;
        end
`ifdef ISR_TIMEOUT_EN
        else if (tmr_expire) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end
`endif
      end
      default: begin
        state_next     = IDLE;
        cmd_valid_next = 1'b0;
      end
    endcase
  end

  // State, pointer, command and per-stream flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 3'd7;
      cmd_valid_reg  <= 1'b0;
      cmd_stream_reg <= 3'd0;
      pending_reg    <= 8'd0;
      overrun_reg    <= 8'd0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      cmd_valid_reg  <= cmd_valid_next;
      cmd_stream_reg <= cmd_stream_next;
      pending_reg    <= pending_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign cmd_valid  = cmd_valid_reg;
  assign cmd_stream = cmd_stream_reg;
  assign pending    = pending_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_ion_sensor_request_arbiter.sv
// Self-checking bench for ion_sensor_request_arbiter. Expected grant streams
// are pushed to a scoreboard queue when requests are driven and popped when
// the DUT offers a command. Timeout behaviour follows ISR_TIMEOUT_EN.
module tb_ion_sensor_request_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] stream_active;
  logic [7:0] i_s_request;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_valid;
  logic [2:0] cmd_stream;
  logic [7:0] pending;
  logic [7:0] overrun;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  ion_sensor_request_arbiter #(.timeout_cycles(16'd5)) dut (
    .clock        (clock),
    .reset        (reset),
    .stream_active(stream_active),
    .i_s_request  (i_s_request),
    .cmd_ready    (cmd_ready),
    .cmd_done     (cmd_done),
    .cmd_valid    (cmd_valid),
    .cmd_stream   (cmd_stream),
    .pending      (pending),
    .overrun      (overrun),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  // Advance one cycle; inputs set after this take effect at the next edge,
  // outputs read after this reflect the edge just taken.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] req);
    i_s_request = req;
    tick();
    i_s_request = 8'h00;
  endtask

  // Wait (bounded) for cmd_valid, then compare the stream with the scoreboard
  task automatic wait_cmd(input string tag);
    int exp_s;
    for (int i = 0; i < 20 && !cmd_valid; i++) tick();
    check({tag, "_valid"}, cmd_valid, 1);
    exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    check({tag, "_stream"}, cmd_stream, exp_s);
    $display("cmd %s: stream %0d (expected %0d)", tag, cmd_stream, exp_s);
  endtask

  // Stall one cycle, accept the command, then complete it
  task automatic serve(input string tag);
    logic [2:0] s;
    wait_cmd(tag);
    s = cmd_stream;
    tick();
    check({tag, "_hold"}, {cmd_valid, cmd_stream}, {1'b1, s});
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check({tag, "_accepted"}, {cmd_valid, busy}, 2'b01);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    stream_active = 8'hFF;
    i_s_request   = 8'h00;
    cmd_ready     = 1'b0;
    cmd_done      = 1'b0;
    do_reset();

    // Reset state
    check("rst_outputs", {cmd_valid, cmd_stream, pending, overrun, busy, timeout}, 0);

    // Single request: pending next cycle, command the cycle after
    exp_q.push_back(2);
    pulse(8'h04);
    check("single_pending", pending, 8'h04);
    check("single_not_yet_valid", cmd_valid, 0);
    tick();
    wait_cmd("single");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("single_wait", {cmd_valid, busy, pending}, {1'b0, 1'b1, 8'h00});
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check("single_idle", busy, 0);

    // Round-robin from a fresh pointer: 0 then 7, twice
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(7);
    pulse(8'h81);
    serve("rr_a0");
    serve("rr_a7");
    exp_q.push_back(0);
    exp_q.push_back(7);
    pulse(8'h81);
    serve("rr_b0");
    serve("rr_b7");

    // Overrun: park the block in WAIT so stream 3 cannot be granted
    exp_q.push_back(0);
    pulse(8'h01);
    wait_cmd("ovr_hold");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    pulse(8'h08);
    check("ovr_first_no_flag", overrun, 8'h00);
    pulse(8'h08);
    check("ovr_set", {pending, overrun}, {8'h08, 8'h08});
    tick();
    tick();
    check("ovr_sticky", overrun, 8'h08);
    stream_active = 8'hF7;
    tick();
    check("ovr_inactive_clear", {pending, overrun}, 16'h0000);
    pulse(8'h08);
    check("ovr_inactive_ignored", pending, 8'h00);
    stream_active = 8'hFF;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    tick();
    tick();
    check("ovr_nothing_issued", {cmd_valid, busy}, 2'b00);

    // Grant/request collision on stream 1
    exp_q.push_back(1);
    exp_q.push_back(1);
    pulse(8'h02);
    pulse(8'h02);
    check("coll_granted", {cmd_valid, cmd_stream}, {1'b1, 3'd1});
    check("coll_pending_kept", pending, 8'h02);
    check("coll_no_overrun", overrun, 8'h00);
    serve("coll_a");
    serve("coll_b");

    // Timeout behaviour in WAIT
    exp_q.push_back(0);
    pulse(8'h01);
    wait_cmd("tmo");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
`ifdef ISR_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tmo_waiting", {busy, timeout}, 2'b10);
    end
    tick();
    check("tmo_pulse", {busy, timeout}, 2'b01);
    tick();
    check("tmo_pulse_end", {busy, timeout}, 2'b00);
`else
    for (int i = 0; i < 20; i++) tick();
    check("tmo_stays_wait", {busy, timeout}, 2'b10);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check("tmo_done_idle", busy, 0);
`endif

    // Reset while a command is offered, then stream 0 wins again
    exp_q.push_back(3);
    pulse(8'h08);
    wait_cmd("rst_issue");
    reset = 1'b1;
    tick();
    check("rst_issue_outputs", {cmd_valid, cmd_stream, pending, overrun, busy, timeout}, 0);
    reset = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(7);
    pulse(8'h81);
    serve("post_rst0");
    serve("post_rst7");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
